memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Memory-access (MA) stage of the multi-cycle RockWave RV32 core, bundled with its word-organised data RAM. Takes execute-stage results (`*_em`), issues byte-lane-correct loads and stores, and performs CSR access. Presents aligned, sign- or zero-extended load data and registered pipeline state (`*_mw`) to write-back.

## Interface
- `XLEN`, default 32: data width.
- `AWIDTH`, default 16: RAM word-address width (2^AWIDTH words).
- `OPLEN`, package value: decoded-op width.
- Ports, all clock domain `clk`:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `phase_fetch`, `phase_decode`, `phase_execute`, `phase_writeback` in 1: phase one-hots; unused except for observation.
- `phase_memoryaccess` in 1: MA phase qualifier.
- `decoded_op_em` in OPLEN: decoded op; contains the `FUNCT3` field and `DATA_MEM_WE_BIT`.
- `jump_state_em` in 1, `rdsel_em` in 5, `curr_pc_em` in XLEN: pass-through state.
- `alu_out_em` in XLEN: effective byte address, or CSR address in bits [11:0].
- `rs2data_em` in XLEN: store / CSR write data.
- `csr_rdata` in XLEN: CSR read data.
- `csr_addr` out 12, `csr_wdata` out XLEN, `csr_we` out 2: CSR port.
- `decoded_op_mw` out OPLEN, `jump_state_mw` out 1, `rdsel_mw` out 5, `curr_pc_mw` out XLEN, `alu_out_mw` out XLEN, `csr_out_mw` out XLEN: registered outputs to write-back.
- `mem_out_mw` out XLEN: extended load data.
- `stall_memoryaccess` out 1: tied 0.

## Operation
- Word address = `alu_out_em[AWIDTH+1:2]`; lane offset `a = alu_out_em[1:0]`.
- Write data = `rs2data_em << (8*a)`, truncated to 32 bits. Example: SH at 0x6 with rs2 0xDEADAAAA gives 0xAAAA0000.
- Byte strobes, selected by FUNCT3:
  - B: `4'b0001 << a`.
  - H: `4'b0011 << a`, truncated to 4 bits.
  - W: `4'b1111`.
- Strobes are non-zero only when `phase_memoryaccess & decoded_op_em[DATA_MEM_WE_BIT] & !rst`.
- Load path: read word `>> (8*a)`, then extend by FUNCT3:
  - B: sign-extend bit 7.
  - BU: zero-extend 8.
  - H: sign-extend bit 15.
  - HU: zero-extend 16.
  - W: whole word.
- `mem_out_mw` is combinational from RAM output, FUNCT3 and `a`. Upstream holds `*_em` stable through MA and WB.
- CSR port:
  - `csr_addr = alu_out_em[11:0]`, `csr_wdata = rs2data_em`.
  - `csr_we = decoded_op_em[CSR_WE_BIT_M:CSR_WE_BIT_L]`, gated by `phase_memoryaccess`.
- RAM:
  - 2^AWIDTH x 32, per-byte write enable, no content reset.
  - Write-first on the same address.

## Timing
- Pipeline registers (`decoded_op_mw`, `jump_state_mw`, `rdsel_mw`, `curr_pc_mw`, `alu_out_mw`, `csr_out_mw <= csr_rdata`) load on `clk` when `phase_memoryaccess=1`, otherwise hold. All reset to 0.
- RAM read is registered: read data = RAM[word addr] sampled every edge, reset value 0.
  - Address is valid from execute start, so read data is valid throughout MA (1-cycle latency).
- Store commits on the MA-cycle edge.
- Store followed by a load from the same word in a later instruction returns the new data.
- During `rst`: all strobes 0, all registers 0.
- Reset mid-MA aborts the store.

## Configuration
- `MEMACC_MISALIGN_CHECK_EN` defined:
  - H with `a[0]=1`, or W with `a!=0`, forces strobes to 0 and `mem_out_mw` to 0.
- Undefined: no check; lanes shifted past byte 3 are dropped.

## Structure
- Package `core_general_pkg` holds:
  - Widths: `XLEN`, `AWIDTH`, `OPLEN`.
  - Field positions: `FUNCT3_BIT_M/L`, `DATA_MEM_WE_BIT`, `CSR_WE_BIT_M/L`.
  - FUNCT3 codes: B=000, H=001, W=010, BU=100, HU=101.
- Sub-module `data_ram`: byte-enable synchronous RAM. Ports `clk`, `rst`, `addr`, `qin`, `qout`, `we[3:0]`.

## Test plan
- SB of 0x55 at 0x0/0x1/0x2/0x3:
  - wdata = 0x00000055 / 0x00005500 / 0x00550000 / 0x55000000.
  - Strobes = 0001 / 0010 / 0100 / 1000.
- SH of 0xDEADAAAA at 0x4 gives wdata 0xDEADAAAA, strobes 0011. At 0x6 gives wdata 0xAAAA0000, strobes 1100.
- SW of 0xDEADBEEF at 0x8 gives wdata 0xDEADBEEF, strobes 1111.
- SW 0xFFFFFFFF at 0xC, then LB 0xC gives 0xFFFFFFFF; LBU 0xC gives 0x000000FF.
- SW 0xAAAAAAAA at 0x10: LH gives 0xFFFFAAAA, LHU gives 0x0000AAAA. SW 0x55555555 at 0x14, then LW gives 0x55555555.
- Store with WE set but `phase_memoryaccess=0`, or `rst=1`: RAM unchanged, all `*_mw` registers 0 after reset.

Source files
------------

// File: rtl/core_general_pkg.sv
// Shared widths, decoded-op field positions and FUNCT3 codes for the RockWave RV32 core.
package core_general_pkg;

  localparam int XLEN   = 32;
  localparam int AWIDTH = 16;
  localparam int OPLEN  = 16;

  localparam int FUNCT3_BIT_M    = 2;
  localparam int FUNCT3_BIT_L    = 0;
  localparam int DATA_MEM_WE_BIT = 3;
  localparam int CSR_WE_BIT_M    = 5;
  localparam int CSR_WE_BIT_L    = 4;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // Store byte strobes for a given access size and lane offset; lanes past byte 3 fall off.
  function automatic logic [3:0] store_strobes(input logic [2:0] funct3, input logic [1:0] offset);
    logic [3:0] strobes;
    case (funct3[1:0])
      2'b00:   strobes = 4'b0001 << offset;
      2'b01:   strobes = 4'b0011 << offset;
      default: strobes = 4'b1111;
    endcase
    return strobes;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Word-organised data RAM with per-byte write enables, registered write-first read.
module data_ram #(
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic [31:0]       qin,
  output logic [31:0]       qout,
  input  logic [3:0]        we
);

  localparam int DEPTH = 2 ** AWIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge clk) begin
        if (we[gi] && !rst) begin
          lane_mem[addr] <= qin[8*gi +: 8];
        end
      end

      // Write-first: a lane being written returns the incoming byte on the same edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_reg <= 8'h00;
        end else if (we[gi]) begin
          rd_reg <= qin[8*gi +: 8];
        end else begin
          rd_reg <= lane_mem[addr];
        end
      end

      assign qout[8*gi +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access stage: byte-lane loads/stores into data_ram, CSR port, MA->WB pipeline registers.
// Optional MEMACC_MISALIGN_CHECK_EN suppresses misaligned halfword/word accesses.
module memory_access_stage #(
  parameter int XLEN   = core_general_pkg::XLEN,
  parameter int AWIDTH = core_general_pkg::AWIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             phase_fetch,
  input  logic                             phase_decode,
  input  logic                             phase_execute,
  input  logic                             phase_memoryaccess,
  input  logic                             phase_writeback,
  input  logic [core_general_pkg::OPLEN-1:0] decoded_op_em,
  input  logic                             jump_state_em,
  input  logic [4:0]                       rdsel_em,
  input  logic [XLEN-1:0]                  curr_pc_em,
  input  logic [XLEN-1:0]                  alu_out_em,
  input  logic [XLEN-1:0]                  rs2data_em,
  input  logic [XLEN-1:0]                  csr_rdata,
  output logic [11:0]                      csr_addr,
  output logic [XLEN-1:0]                  csr_wdata,
  output logic [1:0]                       csr_we,
  output logic [core_general_pkg::OPLEN-1:0] decoded_op_mw,
  output logic                             jump_state_mw,
  output logic [4:0]                       rdsel_mw,
  output logic [XLEN-1:0]                  curr_pc_mw,
  output logic [XLEN-1:0]                  alu_out_mw,
  output logic [XLEN-1:0]                  csr_out_mw,
  output logic [XLEN-1:0]                  mem_out_mw,
  output logic                             stall_memoryaccess
);

  import core_general_pkg::*;

  logic [1:0]        lane_offset;
  logic [AWIDTH-1:0] word_addr;
  logic [2:0]        funct3;
  logic              misalign;
  logic [3:0]        lane_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       rdata_shifted;
  logic [XLEN-1:0]   load_ext;
  logic              unused_phases;

  assign lane_offset = alu_out_em[1:0];
  assign word_addr   = alu_out_em[AWIDTH+1:2];
  assign funct3      = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];

  assign unused_phases      = ^{phase_fetch, phase_decode, phase_execute, phase_writeback};
  assign stall_memoryaccess = 1'b0;

`ifdef MEMACC_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign = lane_offset[0];
      2'b10:   misalign = (lane_offset != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    lane_we = 4'b0000;
    if (phase_memoryaccess && decoded_op_em[DATA_MEM_WE_BIT] && !rst && !misalign) begin
      lane_we = store_strobes(funct3, lane_offset);
    end
  end

  assign ram_wdata = rs2data_em[31:0] << {lane_offset, 3'b000};

  data_ram #(
    .AWIDTH(AWIDTH)
  ) u_data_ram (
    .clk  (clk),
    .rst  (rst),
    .addr (word_addr),
    .qin  (ram_wdata),
    .qout (ram_rdata),
    .we   (lane_we)
  );

  // Load alignment/extension stays combinational; upstream holds *_em stable across MA and WB.
  assign rdata_shifted = ram_rdata >> {lane_offset, 3'b000};

  always_comb begin
    load_ext = '0;
    if (!misalign) begin
      case (funct3)
        F3_B:    load_ext = XLEN'($signed(rdata_shifted[7:0]));
        F3_BU:   load_ext = XLEN'(rdata_shifted[7:0]);
        F3_H:    load_ext = XLEN'($signed(rdata_shifted[15:0]));
        F3_HU:   load_ext = XLEN'(rdata_shifted[15:0]);
        default: load_ext = XLEN'(rdata_shifted);
      endcase
    end
  end

  assign mem_out_mw = load_ext;

  assign csr_addr  = alu_out_em[11:0];
  assign csr_wdata = rs2data_em;
  assign csr_we    = phase_memoryaccess ? decoded_op_em[CSR_WE_BIT_M:CSR_WE_BIT_L] : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      decoded_op_mw <= '0;
      jump_state_mw <= 1'b0;
      rdsel_mw      <= '0;
      curr_pc_mw    <= '0;
      alu_out_mw    <= '0;
      csr_out_mw    <= '0;
    end else if (phase_memoryaccess) begin
      decoded_op_mw <= decoded_op_em;
      jump_state_mw <= jump_state_em;
      rdsel_mw      <= rdsel_em;
      curr_pc_mw    <= curr_pc_em;
      alu_out_mw    <= alu_out_em;
      csr_out_mw    <= csr_rdata;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: expected results queued at issue, compared at MA/WB.
module tb_memory_access_stage;
  import core_general_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              phase_fetch = 1'b0, phase_decode = 1'b0, phase_execute = 1'b0;
  logic              phase_memoryaccess = 1'b0, phase_writeback = 1'b0;
  logic [OPLEN-1:0]  decoded_op_em = '0;
  logic              jump_state_em = 1'b0;
  logic [4:0]        rdsel_em = '0;
  logic [XLEN-1:0]   curr_pc_em = '0, alu_out_em = '0, rs2data_em = '0, csr_rdata = '0;
  logic [11:0]       csr_addr;
  logic [XLEN-1:0]   csr_wdata;
  logic [1:0]        csr_we;
  logic [OPLEN-1:0]  decoded_op_mw;
  logic              jump_state_mw;
  logic [4:0]        rdsel_mw;
  logic [XLEN-1:0]   curr_pc_mw, alu_out_mw, csr_out_mw, mem_out_mw;
  logic              stall_memoryaccess;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        jmp;
  } mw_t;
  mw_t mw_q [$];

  memory_access_stage dut (
    .clk(clk), .rst(rst),
    .phase_fetch(phase_fetch), .phase_decode(phase_decode), .phase_execute(phase_execute),
    .phase_memoryaccess(phase_memoryaccess), .phase_writeback(phase_writeback),
    .decoded_op_em(decoded_op_em), .jump_state_em(jump_state_em), .rdsel_em(rdsel_em),
    .curr_pc_em(curr_pc_em), .alu_out_em(alu_out_em), .rs2data_em(rs2data_em),
    .csr_rdata(csr_rdata), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we),
    .decoded_op_mw(decoded_op_mw), .jump_state_mw(jump_state_mw), .rdsel_mw(rdsel_mw),
    .curr_pc_mw(curr_pc_mw), .alu_out_mw(alu_out_mw), .csr_out_mw(csr_out_mw),
    .mem_out_mw(mem_out_mw), .stall_memoryaccess(stall_memoryaccess)
  );

  always #5 clk = ~clk;

  function automatic logic [OPLEN-1:0] mk_op(input logic [2:0] f3, input logic we, input logic [1:0] cwe);
    logic [OPLEN-1:0] op;
    op = '0;
    op[FUNCT3_BIT_M:FUNCT3_BIT_L] = f3;
    op[DATA_MEM_WE_BIT] = we;
    op[CSR_WE_BIT_M:CSR_WE_BIT_L] = cwe;
    return op;
  endfunction

  // Reference load extension from a stored word.
  function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = (off == 2'd3) ? {8'h00, w[31:24]} : w[8*off +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w >> (8*off);
    endcase
  endfunction

  // One instruction: execute cycle, MA cycle (load sampled), then WB cycle.
  task automatic run_op(input logic [2:0] f3, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic ma_en, output logic [31:0] ld);
    @(negedge clk);
    decoded_op_em = mk_op(f3, we, 2'b00);
    alu_out_em = addr;
    rs2data_em = data;
    phase_writeback = 1'b0;
    phase_execute = 1'b1;
    @(negedge clk);
    phase_execute = 1'b0;
    phase_memoryaccess = ma_en;
    #1 ld = mem_out_mw;
    @(negedge clk);
    phase_memoryaccess = 1'b0;
    phase_writeback = 1'b1;
    #1;
  endtask

  task automatic load_check(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] expected);
    logic [31:0] ld, exp_v;
    exp_q.push_back(expected);
    run_op(f3, 1'b0, addr, 32'h0, 1'b1, ld);
    exp_v = exp_q.pop_front();
    checks++;
    if (ld !== exp_v) begin
      failures++;
      $display("FAIL %s addr=0x%08h got=0x%08h expected=0x%08h", name, addr, ld, exp_v);
    end else
      $display("ok   %s addr=0x%08h data=0x%08h", name, addr, ld);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    decoded_op_em = mk_op(F3_W, 1'b1, 2'b11);
    alu_out_em = 32'h14; rs2data_em = 32'hA5A5A5A5; rdsel_em = 5'd7; curr_pc_em = 32'h100;
    jump_state_em = 1'b1; csr_rdata = 32'h1111_2222;
    phase_memoryaccess = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (decoded_op_mw !== '0) begin failures++; $display("FAIL reset_op got=%h expected=0", decoded_op_mw); end
    checks++; if (rdsel_mw !== 5'd0) begin failures++; $display("FAIL reset_rd got=%h expected=0", rdsel_mw); end
    checks++; if (curr_pc_mw !== '0) begin failures++; $display("FAIL reset_pc got=%h expected=0", curr_pc_mw); end
    checks++; if (alu_out_mw !== '0) begin failures++; $display("FAIL reset_alu got=%h expected=0", alu_out_mw); end
    checks++; if (csr_out_mw !== '0) begin failures++; $display("FAIL reset_csr got=%h expected=0", csr_out_mw); end
    checks++; if (jump_state_mw !== 1'b0) begin failures++; $display("FAIL reset_jump got=%b expected=0", jump_state_mw); end
    checks++; if (mem_out_mw !== '0) begin failures++; $display("FAIL reset_mem got=%h expected=0", mem_out_mw); end
    checks++; if (stall_memoryaccess !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b expected=0", stall_memoryaccess); end
    $display("reset: checked pipeline registers and load data held at zero");
    @(negedge clk);
    rst = 1'b0;
    phase_memoryaccess = 1'b0;
    jump_state_em = 1'b0;
  endtask

  task automatic test_store_byte();
    logic [31:0] ld;
    for (int k = 0; k < 4; k++) begin
      run_op(F3_W, 1'b1, 32'h40 + 4*k, 32'h0, 1'b1, ld);
      run_op(F3_B, 1'b1, 32'h40 + 4*k + k, 32'h0000_0055, 1'b1, ld);
      load_check($sformatf("sb_lane%0d", k), F3_W, 32'h40 + 4*k, 32'h55 << (8*k));
    end
  endtask

  task automatic test_store_half();
    logic [31:0] ld;
    run_op(F3_W, 1'b1, 32'h4, 32'h0, 1'b1, ld);
    run_op(F3_H, 1'b1, 32'h4, 32'hDEADAAAA, 1'b1, ld);
    load_check("sh_off0", F3_W, 32'h4, 32'h0000AAAA);
    run_op(F3_W, 1'b1, 32'h24, 32'h0, 1'b1, ld);
    run_op(F3_H, 1'b1, 32'h26, 32'hDEADAAAA, 1'b1, ld);
    load_check("sh_off2", F3_W, 32'h24, 32'hAAAA0000);
  endtask

  task automatic test_store_word();
    logic [31:0] ld;
    run_op(F3_W, 1'b1, 32'h8, 32'hDEADBEEF, 1'b1, ld);
    load_check("sw_word", F3_W, 32'h8, 32'hDEADBEEF);
    load_check("lh_off2", F3_H, 32'hA, 32'hFFFFDEAD);
    load_check("lb_off3", F3_B, 32'hB, 32'hFFFFFFDE);
`ifdef MEMACC_MISALIGN_CHECK_EN
    load_check("lw_misaligned", F3_W, 32'hA, 32'h00000000);
`else
    load_check("lw_misaligned", F3_W, 32'hA, 32'h0000DEAD);
`endif
  endtask

  task automatic test_load_ext();
    logic [31:0] ld;
    run_op(F3_W, 1'b1, 32'hC, 32'hFFFFFFFF, 1'b1, ld);
    load_check("lb_sign", F3_B, 32'hC, 32'hFFFFFFFF);
    load_check("lbu_zero", F3_BU, 32'hC, 32'h000000FF);
    run_op(F3_W, 1'b1, 32'h10, 32'hAAAAAAAA, 1'b1, ld);
    load_check("lh_sign", F3_H, 32'h10, 32'hFFFFAAAA);
    load_check("lhu_zero", F3_HU, 32'h10, 32'h0000AAAA);
    run_op(F3_W, 1'b1, 32'h14, 32'h55555555, 1'b1, ld);
    load_check("lw_word", F3_W, 32'h14, 32'h55555555);
  endtask

  task automatic test_gating();
    logic [31:0] ld;
    run_op(F3_W, 1'b1, 32'h14, 32'h12345678, 1'b0, ld);
    load_check("no_ma_store", F3_W, 32'h14, 32'h55555555);
    rdsel_em = 5'd9; curr_pc_em = 32'h2000;
    @(negedge clk);
    decoded_op_em = mk_op(F3_W, 1'b1, 2'b00);
    alu_out_em = 32'h14; rs2data_em = 32'h0BADF00D;
    phase_writeback = 1'b0; phase_execute = 1'b1;
    @(negedge clk);
    phase_execute = 1'b0; phase_memoryaccess = 1'b1; rst = 1'b1;
    @(negedge clk);
    phase_memoryaccess = 1'b0; rst = 1'b0;
    #1;
    checks++; if (rdsel_mw !== 5'd0) begin failures++; $display("FAIL rst_mid_ma_rd got=%h expected=0", rdsel_mw); end
    checks++; if (curr_pc_mw !== '0) begin failures++; $display("FAIL rst_mid_ma_pc got=%h expected=0", curr_pc_mw); end
    $display("rst mid-MA: rd=%0d pc=0x%08h", rdsel_mw, curr_pc_mw);
    load_check("rst_store_abort", F3_W, 32'h14, 32'h55555555);
  endtask

  task automatic test_csr();
    logic [OPLEN-1:0] op;
    op = mk_op(F3_W, 1'b0, 2'b10);
    @(negedge clk);
    decoded_op_em = op; alu_out_em = 32'h00ABC305; rs2data_em = 32'h12345678;
    csr_rdata = 32'hCAFEF00D; phase_writeback = 1'b0; phase_memoryaccess = 1'b0;
    #1;
    checks++; if (csr_we !== 2'b00) begin failures++; $display("FAIL csr_we_idle got=%b expected=00", csr_we); end
    checks++; if (csr_addr !== 12'h305) begin failures++; $display("FAIL csr_addr got=%h expected=305", csr_addr); end
    checks++; if (csr_wdata !== 32'h12345678) begin failures++; $display("FAIL csr_wdata got=%h expected=12345678", csr_wdata); end
    @(negedge clk);
    phase_memoryaccess = 1'b1;
    #1;
    checks++; if (csr_we !== 2'b10) begin failures++; $display("FAIL csr_we_ma got=%b expected=10", csr_we); end
    @(negedge clk);
    phase_memoryaccess = 1'b0;
    #1;
    checks++; if (csr_out_mw !== 32'hCAFEF00D) begin failures++; $display("FAIL csr_out got=%h expected=cafef00d", csr_out_mw); end
    checks++; if (decoded_op_mw !== op) begin failures++; $display("FAIL csr_op_mw got=%h expected=%h", decoded_op_mw, op); end
    $display("csr: addr=0x%03h wdata=0x%08h out=0x%08h", csr_addr, csr_wdata, csr_out_mw);
  endtask

  task automatic test_back_to_back();
    logic [31:0] model [8];
    logic [31:0] ld, addr;
    logic [2:0]  f3s [5];
    logic [2:0]  f3;
    logic [1:0]  off;
    mw_t         m, e;
    f3s[0] = F3_B; f3s[1] = F3_BU; f3s[2] = F3_H; f3s[3] = F3_HU; f3s[4] = F3_W;
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      m.rd = 5'($urandom); m.pc = $urandom; m.alu = 32'h400 + 4*i; m.jmp = 1'($urandom);
      rdsel_em = m.rd; curr_pc_em = m.pc; jump_state_em = m.jmp;
      mw_q.push_back(m);
      run_op(F3_W, 1'b1, m.alu, model[i], 1'b1, ld);
      e = mw_q.pop_front();
      checks++;
      if (rdsel_mw !== e.rd || curr_pc_mw !== e.pc || alu_out_mw !== e.alu || jump_state_mw !== e.jmp) begin
        failures++;
        $display("FAIL b2b_mw%0d got rd=%0d pc=%h alu=%h j=%b expected rd=%0d pc=%h alu=%h j=%b",
                 i, rdsel_mw, curr_pc_mw, alu_out_mw, jump_state_mw, e.rd, e.pc, e.alu, e.jmp);
      end else
        $display("ok   b2b_sw%0d addr=0x%08h data=0x%08h", i, e.alu, model[i]);
    end
    for (int i = 0; i < 12; i++) begin
      int w;
      w = $urandom_range(0, 7);
      f3 = f3s[$urandom_range(0, 4)];
      off = 2'($urandom);
      if (f3[1:0] == 2'b01) off[0] = 1'b0;
      if (f3[1:0] == 2'b10) off = 2'b00;
      addr = 32'h400 + 4*w + 32'(off);
      load_check($sformatf("b2b_ld%0d_f3_%0d", i, f3), f3, addr, ext_model(model[w], f3, off));
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_half();
    test_store_word();
    test_load_ext();
    test_gating();
    test_csr();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
